// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state codes, ALU op codes,
// opcode/funct constants, datapath select codes and the control-word struct.
// Optional illegal-instruction trap: MCPU_CTRL_ILLEGAL_TRAP_EN.
package mcpu_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALUOP_W = 3;

`ifdef MCPU_CTRL_ILLEGAL_TRAP_EN
  typedef enum logic [STATE_W-1:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExe     = 4'd2,
    StMemRd   = 4'd3,
    StMemWr   = 4'd4,
    StWbMem   = 4'd5,
    StWbAlu   = 4'd6,
    StBranch  = 4'd7,
    StJump    = 4'd8,
    StIllegal = 4'd9
  } state_e;
`else
  typedef enum logic [STATE_W-1:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StExe    = 4'd2,
    StMemRd  = 4'd3,
    StMemWr  = 4'd4,
    StWbMem  = 4'd5,
    StWbAlu  = 4'd6,
    StBranch = 4'd7,
    StJump   = 4'd8
  } state_e;
`endif

  localparam logic [ALUOP_W-1:0] ALUOP_ADD = 3'd0;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB = 3'd1;
  localparam logic [ALUOP_W-1:0] ALUOP_AND = 3'd2;
  localparam logic [ALUOP_W-1:0] ALUOP_OR  = 3'd3;
  localparam logic [ALUOP_W-1:0] ALUOP_SLT = 3'd4;
  localparam logic [ALUOP_W-1:0] ALUOP_LUI = 3'd5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_JMP = 2'd2;
  localparam logic [1:0] NPC_RS  = 2'd3;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_BYTE = 2'd2;
  localparam logic [1:0] WD_PC   = 2'd3;

  localparam logic [1:0] GPR_RD = 2'd0;
  localparam logic [1:0] GPR_RT = 2'd1;
  localparam logic [1:0] GPR_RA = 2'd2;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  // Complete control word; zero means "idle, no side effects".
  typedef struct packed {
    logic               pc_write;
    logic               ir_write;
    logic               reg_write;
    logic               mem_write;
    logic               iord;
    logic               ext16_op;
    logic               ext8_op;
    logic               alusrca;
    logic [1:0]         alusrcb;
    logic [ALUOP_W-1:0] aluop;
    logic [1:0]         gpr_sel;
    logic [1:0]         wd_sel;
    logic [1:0]         npc_op;
    logic               instr_done;
  } ctl_t;

  function automatic logic is_load(logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/mcpu_ctrl_if.sv
// Control-unit to datapath bundle. master = control unit, slave = datapath.
// Optional illegal-instruction flag: MCPU_CTRL_ILLEGAL_TRAP_EN.
interface mcpu_ctrl_if;
  logic [5:0]                   op;
  logic [5:0]                   funct;
  logic                         zero;
  logic                         pc_write;
  logic                         ir_write;
  logic                         reg_write;
  logic                         mem_write;
  logic                         iord;
  logic                         ext16_op;
  logic                         ext8_op;
  logic                         alusrca;
  logic [1:0]                   alusrcb;
  logic [mcpu_pkg::ALUOP_W-1:0] aluop;
  logic [1:0]                   gpr_sel;
  logic [1:0]                   wd_sel;
  logic [1:0]                   npc_op;
  logic                         instr_done;
  logic [31:0]                  retired;
`ifdef MCPU_CTRL_ILLEGAL_TRAP_EN
  logic                         illegal;

  modport master (
    input  op, funct, zero,
    output pc_write, ir_write, reg_write, mem_write, iord, ext16_op, ext8_op, alusrca,
           alusrcb, aluop, gpr_sel, wd_sel, npc_op, instr_done, retired, illegal
  );
  modport slave (
    output op, funct, zero,
    input  pc_write, ir_write, reg_write, mem_write, iord, ext16_op, ext8_op, alusrca,
           alusrcb, aluop, gpr_sel, wd_sel, npc_op, instr_done, retired, illegal
  );
`else
  modport master (
    input  op, funct, zero,
    output pc_write, ir_write, reg_write, mem_write, iord, ext16_op, ext8_op, alusrca,
           alusrcb, aluop, gpr_sel, wd_sel, npc_op, instr_done, retired
  );
  modport slave (
    output op, funct, zero,
    input  pc_write, ir_write, reg_write, mem_write, iord, ext16_op, ext8_op, alusrca,
           alusrcb, aluop, gpr_sel, wd_sel, npc_op, instr_done, retired
  );
`endif
endinterface

// File: rtl/mcpu_alu_dec.sv
// Combinational decode of op/funct into the ALU operation and 16-bit extender mode used in
// EXE. legal_o flags instructions that take the EXE path (ALU ops, loads, stores).
module mcpu_alu_dec
  import mcpu_pkg::*;
(
  input  logic [5:0]         op_i,
  input  logic [5:0]         funct_i,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic               ext16_op_o,
  output logic               legal_o
);

  // Map opcode (and funct for R-type) to ALU control.
  always_comb begin
    aluop_o    = ALUOP_ADD;
    ext16_op_o = 1'b0;
    legal_o    = 1'b1;
    case (op_i)
      OP_RTYPE: begin
        case (funct_i)
          FN_ADDU: aluop_o = ALUOP_ADD;
          FN_SUBU: aluop_o = ALUOP_SUB;
          FN_AND:  aluop_o = ALUOP_AND;
          FN_OR:   aluop_o = ALUOP_OR;
          FN_SLT:  aluop_o = ALUOP_SLT;
          default: legal_o = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_LB, OP_LBU: begin
        aluop_o    = ALUOP_ADD;
        ext16_op_o = 1'b1;
      end
      OP_ANDI: aluop_o = ALUOP_AND;
      OP_ORI:  aluop_o = ALUOP_OR;
      OP_LUI:  aluop_o = ALUOP_LUI;
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing FETCH/DECODE/EXE/MEM/WB per instruction
// and counting retired instructions. Optional trap on unsupported instructions:
// MCPU_CTRL_ILLEGAL_TRAP_EN (otherwise they retire nothing and behave as a NOP).
module mcpu_ctrl
  import mcpu_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  mcpu_ctrl_if.master bus
);

  state_e             state_q, state_d;
  logic [31:0]        retired_q;
  ctl_t               ctl, ctl_out;
  logic [ALUOP_W-1:0] dec_aluop;
  logic               dec_ext16;
  logic               dec_legal;
  logic               is_rtype, is_jr, is_jump, is_branch;

  mcpu_alu_dec u_alu_dec (
    .op_i       (bus.op),
    .funct_i    (bus.funct),
    .aluop_o    (dec_aluop),
    .ext16_op_o (dec_ext16),
    .legal_o    (dec_legal)
  );

  assign is_rtype  = (bus.op == OP_RTYPE);
  assign is_jr     = is_rtype && (bus.funct == FN_JR);
  assign is_jump   = (bus.op == OP_J) || (bus.op == OP_JAL) || is_jr;
  assign is_branch = (bus.op == OP_BEQ) || (bus.op == OP_BNE);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control word.
  always_comb begin
    ctl     = '0;
    state_d = state_q;
    case (state_q)
      StFetch: begin
        ctl.ir_write = 1'b1;
        ctl.pc_write = 1'b1;
        ctl.alusrcb  = SRCB_FOUR;
        ctl.aluop    = ALUOP_ADD;
        ctl.npc_op   = NPC_PC4;
        state_d      = StDecode;
      end
      StDecode: begin
        // Branch target is computed speculatively into ALUOut here.
        ctl.alusrcb  = SRCB_IMMSH;
        ctl.aluop    = ALUOP_ADD;
        ctl.ext16_op = 1'b1;
        if (is_jump) begin
          state_d = StJump;
        end else if (is_branch) begin
          state_d = StBranch;
        end else if (dec_legal) begin
          state_d = StExe;
        end else begin
`ifdef MCPU_CTRL_ILLEGAL_TRAP_EN
          state_d = StIllegal;
`else
          state_d = StFetch;
`endif
        end
      end
      StExe: begin
        ctl.alusrca  = 1'b1;
        ctl.alusrcb  = is_rtype ? SRCB_RT : SRCB_IMM;
        ctl.aluop    = dec_aluop;
        ctl.ext16_op = dec_ext16;
        if (is_load(bus.op)) begin
          state_d = StMemRd;
        end else if (bus.op == OP_SW) begin
          state_d = StMemWr;
        end else begin
          state_d = StWbAlu;
        end
      end
      StMemRd: begin
        ctl.iord = 1'b1;
        state_d  = StWbMem;
      end
      StMemWr: begin
        ctl.iord       = 1'b1;
        ctl.mem_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = StFetch;
      end
      StWbMem: begin
        ctl.reg_write  = 1'b1;
        ctl.gpr_sel    = GPR_RT;
        ctl.wd_sel     = (bus.op == OP_LW) ? WD_MEM : WD_BYTE;
        ctl.ext8_op    = (bus.op == OP_LB);
        ctl.instr_done = 1'b1;
        state_d        = StFetch;
      end
      StWbAlu: begin
        ctl.reg_write  = 1'b1;
        ctl.gpr_sel    = is_rtype ? GPR_RD : GPR_RT;
        ctl.wd_sel     = WD_ALU;
        ctl.instr_done = 1'b1;
        state_d        = StFetch;
      end
      StBranch: begin
        ctl.alusrca    = 1'b1;
        ctl.alusrcb    = SRCB_RT;
        ctl.aluop      = ALUOP_SUB;
        ctl.npc_op     = NPC_BR;
        ctl.pc_write   = (bus.op == OP_BEQ) ? bus.zero : ~bus.zero;
        ctl.instr_done = 1'b1;
        state_d        = StFetch;
      end
      StJump: begin
        ctl.pc_write   = 1'b1;
        ctl.npc_op     = is_jr ? NPC_RS : NPC_JMP;
        ctl.instr_done = 1'b1;
        if (bus.op == OP_JAL) begin
          ctl.reg_write = 1'b1;
          ctl.gpr_sel   = GPR_RA;
          ctl.wd_sel    = WD_PC;
        end
        state_d = StFetch;
      end
`ifdef MCPU_CTRL_ILLEGAL_TRAP_EN
      StIllegal: begin
        // Trap: hold with no side effects until reset.
        state_d = StIllegal;
      end
`endif
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Reset forces every output low, including the FETCH enables.
  assign ctl_out = rstn ? ctl : '0;

  // Retired-instruction counter, wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_q <= '0;
    end else if (ctl.instr_done) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign bus.pc_write   = ctl_out.pc_write;
  assign bus.ir_write   = ctl_out.ir_write;
  assign bus.reg_write  = ctl_out.reg_write;
  assign bus.mem_write  = ctl_out.mem_write;
  assign bus.iord       = ctl_out.iord;
  assign bus.ext16_op   = ctl_out.ext16_op;
  assign bus.ext8_op    = ctl_out.ext8_op;
  assign bus.alusrca    = ctl_out.alusrca;
  assign bus.alusrcb    = ctl_out.alusrcb;
  assign bus.aluop      = ctl_out.aluop;
  assign bus.gpr_sel    = ctl_out.gpr_sel;
  assign bus.wd_sel     = ctl_out.wd_sel;
  assign bus.npc_op     = ctl_out.npc_op;
  assign bus.instr_done = ctl_out.instr_done;
  assign bus.retired    = retired_q;
`ifdef MCPU_CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal    = rstn && (state_q == StIllegal);
`endif

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for mcpu_ctrl: a per-instruction cycle model pushes expected control words
// into a scoreboard queue, which is popped and compared once per cycle on the falling edge.
module tb_mcpu_ctrl;
  import mcpu_pkg::*;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       iord;
    logic       ext16_op;
    logic       ext8_op;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] gpr_sel;
    logic [1:0] wd_sel;
    logic [1:0] npc_op;
    logic       instr_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  vec_t        obs;
  vec_t        sb[$];
  vec_t        idle_v = '0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_retired = '0;

  always #5 clk = ~clk;

  mcpu_ctrl_if bus ();

  mcpu_ctrl dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  assign obs = {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write, bus.iord,
                bus.ext16_op, bus.ext8_op, bus.alusrca, bus.alusrcb, bus.aluop,
                bus.gpr_sel, bus.wd_sel, bus.npc_op, bus.instr_done};

  task automatic check_vec(input string tag, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ret(input string tag);
    checks++;
    assert (bus.retired === exp_retired) else begin
      failures++;
      $error("FAIL %s retired observed=%0d expected=%0d", tag, bus.retired, exp_retired);
    end
  endtask

  // Expected control word for every cycle of one instruction.
  task automatic model_push(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    vec_t v;
    v = '0; v.ir_write = 1; v.pc_write = 1; v.alusrcb = 2'd1; sb.push_back(v);
    v = '0; v.alusrcb = 2'd3; v.ext16_op = 1; sb.push_back(v);
    v = '0;
    if (op == 6'h00 && funct inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2A}) begin
      v.alusrca = 1; v.alusrcb = 2'd0;
      case (funct)
        6'h21:   v.aluop = 3'd0;
        6'h23:   v.aluop = 3'd1;
        6'h24:   v.aluop = 3'd2;
        6'h25:   v.aluop = 3'd3;
        default: v.aluop = 3'd4;
      endcase
      sb.push_back(v);
      v = '0; v.reg_write = 1; v.gpr_sel = 2'd0; v.instr_done = 1; sb.push_back(v);
      exp_retired++;
    end else if (op == 6'h00 && funct == 6'h08) begin
      v.pc_write = 1; v.npc_op = 2'd3; v.instr_done = 1; sb.push_back(v);
      exp_retired++;
    end else if (op inside {6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F}) begin
      v.alusrca = 1; v.alusrcb = 2'd2;
      case (op)
        6'h0C:   v.aluop = 3'd2;
        6'h0D:   v.aluop = 3'd3;
        6'h0F:   v.aluop = 3'd5;
        default: begin v.aluop = 3'd0; v.ext16_op = 1; end
      endcase
      sb.push_back(v);
      v = '0; v.reg_write = 1; v.gpr_sel = 2'd1; v.instr_done = 1; sb.push_back(v);
      exp_retired++;
    end else if (op inside {6'h20, 6'h23, 6'h24, 6'h2B}) begin
      v.alusrca = 1; v.alusrcb = 2'd2; v.ext16_op = 1; v.aluop = 3'd0; sb.push_back(v);
      if (op == 6'h2B) begin
        v = '0; v.iord = 1; v.mem_write = 1; v.instr_done = 1; sb.push_back(v);
      end else begin
        v = '0; v.iord = 1; sb.push_back(v);
        v = '0; v.reg_write = 1; v.gpr_sel = 2'd1; v.instr_done = 1;
        v.wd_sel  = (op == 6'h23) ? 2'd1 : 2'd2;
        v.ext8_op = (op == 6'h20);
        sb.push_back(v);
      end
      exp_retired++;
    end else if (op == 6'h04 || op == 6'h05) begin
      v.alusrca = 1; v.alusrcb = 2'd0; v.aluop = 3'd1; v.npc_op = 2'd1; v.instr_done = 1;
      v.pc_write = (op == 6'h04) ? zero : !zero;
      sb.push_back(v);
      exp_retired++;
    end else if (op == 6'h02 || op == 6'h03) begin
      v.pc_write = 1; v.npc_op = 2'd2; v.instr_done = 1;
      if (op == 6'h03) begin v.reg_write = 1; v.gpr_sel = 2'd2; v.wd_sel = 2'd3; end
      sb.push_back(v);
      exp_retired++;
    end
  endtask

  // Called on a falling edge at the start of the instruction's FETCH cycle.
  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] funct,
                     input logic zero);
    vec_t e;
    bus.op = op; bus.funct = funct; bus.zero = zero;
    model_push(op, funct, zero);
    while (sb.size() > 0) begin
      #1;
      e = sb.pop_front();
      check_vec(tag, e);
      @(negedge clk);
    end
    check_ret(tag);
  endtask

  initial begin
    bus.op = '0; bus.funct = '0; bus.zero = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      check_vec("reset_outputs", idle_v);
      check_ret("reset_retired");
    end
    @(negedge clk);
    rstn = 1'b1;

    run("addu",  6'h00, 6'h21, 1'b0);
    run("subu",  6'h00, 6'h23, 1'b0);
    run("and",   6'h00, 6'h24, 1'b0);
    run("or",    6'h00, 6'h25, 1'b0);
    run("slt",   6'h00, 6'h2A, 1'b0);
    run("addi",  6'h08, 6'h00, 1'b0);
    run("addiu", 6'h09, 6'h3F, 1'b0);
    run("andi",  6'h0C, 6'h00, 1'b0);
    run("ori",   6'h0D, 6'h00, 1'b0);
    run("lui",   6'h0F, 6'h00, 1'b0);
    run("lw",    6'h23, 6'h00, 1'b0);
    run("lb",    6'h20, 6'h00, 1'b0);
    run("lbu",   6'h24, 6'h00, 1'b0);
    run("sw",    6'h2B, 6'h00, 1'b0);
    run("beq_z1", 6'h04, 6'h00, 1'b1);
    run("beq_z0", 6'h04, 6'h00, 1'b0);
    run("bne_z1", 6'h05, 6'h00, 1'b1);
    run("bne_z0", 6'h05, 6'h00, 1'b0);
    run("j",     6'h02, 6'h00, 1'b0);
    run("jal",   6'h03, 6'h00, 1'b0);
    run("jr",    6'h00, 6'h08, 1'b0);

    // Reset while a load is in EXE: outputs drop at once and the count clears.
    bus.op = 6'h23; bus.funct = '0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    exp_retired = '0;
    check_vec("midreset_outputs", idle_v);
    check_ret("midreset_retired");
    @(negedge clk);
    rstn = 1'b1;
    run("addu_after_reset", 6'h00, 6'h21, 1'b0);

`ifdef MCPU_CTRL_ILLEGAL_TRAP_EN
    begin
      vec_t e;
      bus.op = 6'h3F; bus.funct = '0;
      model_push(6'h3F, 6'h00, 1'b0);
      while (sb.size() > 0) begin
        #1;
        e = sb.pop_front();
        check_vec("illegal_entry", e);
        @(negedge clk);
      end
      repeat (3) begin
        #1;
        check_vec("illegal_hold", idle_v);
        checks++;
        assert (bus.illegal === 1'b1) else begin
          failures++;
          $error("FAIL illegal_flag observed=%b expected=1", bus.illegal);
        end
        @(negedge clk);
      end
      check_ret("illegal_retired");
    end
`else
    run("nop_op",    6'h3F, 6'h00, 1'b0);
    run("nop_funct", 6'h00, 6'h3F, 1'b0);
    run("addu_after_nop", 6'h00, 6'h21, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcpu_ctrl.md
Name: mcpu_ctrl

Overview:
- Multicycle MIPS control unit. A Moore-style FSM that sequences the shared multicycle datapath (PC, IR, register file, ALU, memory, and the 16-bit and 8-bit sign/zero extenders) one instruction at a time.
- Decodes the latched IR opcode and function fields and drives every datapath enable and mux select, including the extender mode bits.

Parameters:
- STATE_W, 4, width of the state register.
- ALUOP_W, 3, width of the ALU operation code.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  reset; asynchronous assert, active-low.
- op  in  6  IR[31:26], stable after FETCH.
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag, valid in BRANCH.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- reg_write  out  1  register file write enable.
- mem_write  out  1  data memory write enable.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ext16_op  out  1  16-bit extender mode: 1 = sign, 0 = zero.
- ext8_op  out  1  8-bit extender mode: 1 = sign (lb), 0 = zero (lbu).
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
- alusrcb  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = Imm32, 3 = Imm32<<2.
- aluop  out  3  ALU operation: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5.
- gpr_sel  out  2  write register select: 0 = rd, 1 = rt, 2 = $31.
- wd_sel  out  2  write data select: 0 = ALUOut, 1 = MDR word, 2 = MDR byte (via EXT8), 3 = PC.
- npc_op  out  2  next-PC select: 0 = ALU (PC+4), 1 = ALUOut (branch target), 2 = jump target, 3 = rs.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- retired  out  32  count of completed instructions.

Behaviour:
- States: FETCH=0, DECODE=1, EXE=2, MEM_RD=3, MEM_WR=4, WB_MEM=5, WB_ALU=6, BRANCH=7, JUMP=8. Codes 9..15 are unreachable; if entered, the FSM returns to FETCH.
- FETCH: ir_write=1, pc_write=1, iord=0, alusrca=0, alusrcb=1, aluop=ADD, npc_op=0. Next state DECODE.
- DECODE: alusrca=0, alusrcb=3, aluop=ADD, ext16_op=1 (precompute branch target). Next state by op:
  - j/jal -> JUMP.
  - R-type with funct jr (0x08) -> JUMP.
  - beq/bne -> BRANCH.
  - all other supported ops -> EXE.
- EXE: alusrca=1.
  - R-type: alusrcb=0; aluop from funct (addu=ADD, subu=SUB, and=AND, or=OR, slt=SLT).
  - I-type: alusrcb=2.
    - addi/addiu/lw/sw/lb/lbu: ext16_op=1, aluop=ADD.
    - andi: ext16_op=0, aluop=AND.
    - ori: ext16_op=0, aluop=OR.
    - lui: aluop=LUI.
  - Next state: loads -> MEM_RD; sw -> MEM_WR; others -> WB_ALU.
- MEM_RD: iord=1. Next state WB_MEM.
- MEM_WR: iord=1, mem_write=1, instr_done=1. Next state FETCH.
- WB_MEM: reg_write=1, gpr_sel=1; wd_sel=1 for lw, 2 for lb/lbu; ext8_op=1 only for lb. instr_done=1. Next state FETCH.
- WB_ALU: reg_write=1; gpr_sel=0 for R-type, 1 for I-type. instr_done=1. Next state FETCH.
- BRANCH: alusrca=1, alusrcb=0, aluop=SUB, npc_op=1. pc_write = zero for beq, ~zero for bne. instr_done=1. Next state FETCH.
- JUMP: pc_write=1; npc_op=2 for j/jal, 3 for jr. For jal: reg_write=1, gpr_sel=2, wd_sel=3. instr_done=1. Next state FETCH.
- Default: every output not listed for a state is 0.
- Unsupported op or funct: treated as a NOP (DECODE -> FETCH, no writes), unless the optional feature is compiled in.
- Reset: while rstn is low, state=FETCH, retired=0, and all outputs are forced to 0, including ir_write and pc_write. The first FETCH cycle is the first clk edge after rstn rises.
- Reset mid-instruction aborts the instruction with no partial write after assertion.
- retired increments on the clock edge of every instr_done cycle and wraps from 0xFFFFFFFF to 0.
- All outputs are combinational from state, op, funct and zero. Latency per instruction:
  - sw: 4 cycles.
  - lw, lb, lbu: 5 cycles.
  - R-type and ALU I-type: 4 cycles.
  - beq, bne, j, jal, jr: 3 cycles.

Optional Feature:
- Macro: MCPU_CTRL_ILLEGAL_TRAP_EN.
- Defined: adds state ILLEGAL=9, entered from DECODE on an unsupported op or funct. Adds output illegal (1 bit), sticky while in ILLEGAL. The FSM holds in ILLEGAL with all write enables 0 until reset; instr_done is not pulsed.
- Undefined: the illegal port and state are absent; unsupported instructions behave as a NOP as described above.

Decomposition:
- Package mcpu_pkg holds:
  - State encodings.
  - ALUOP_* codes.
  - Opcode constants: OP_RTYPE=0x00, OP_J=0x02, OP_JAL=0x03, OP_BEQ=0x04, OP_BNE=0x05, OP_ADDI=0x08, OP_ADDIU=0x09, OP_ANDI=0x0C, OP_ORI=0x0D, OP_LUI=0x0F, OP_LB=0x20, OP_LW=0x23, OP_LBU=0x24, OP_SW=0x2B.
  - Funct constants.
  - NPC, WD and GPR select codes.
- One natural sub-module, mcpu_alu_dec: combinational op/funct -> aluop and ext16_op decode, used in the EXE state.

Test Plan:
- Reset: rstn low for 3 cycles -> all outputs 0 and retired=0. Release rstn -> ir_write=1 and pc_write=1 on the next cycle.
- addu (op=0, funct=0x21) -> 4 cycles. WB_ALU shows reg_write=1, gpr_sel=0. retired goes 0 -> 1.
- lb (op=0x20) -> EXE with ext16_op=1, alusrcb=2. WB_MEM with wd_sel=2, ext8_op=1. Repeating with lbu gives ext8_op=0. 5 cycles each.
- beq with zero=1 -> pc_write=1 in BRANCH. bne with zero=1 -> pc_write=0. Both take 3 cycles.
- jal (op=0x03) -> JUMP with reg_write=1, gpr_sel=2, wd_sel=3, npc_op=2. jr (funct 0x08) -> npc_op=3, reg_write=0.
- op=0x3F: with MCPU_CTRL_ILLEGAL_TRAP_EN -> illegal=1 and the FSM stays in ILLEGAL. Without it -> FETCH follows DECODE, no write enables asserted, retired unchanged.
